// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and FSM encoding for the conv_out_stream slice
package conv_pkg;

    localparam int DATA_WIDTH_OUT    = 16;
    localparam int ADDRESS_WIDTH_OUT = 6;
    localparam int COUNT_WIDTH       = ADDRESS_WIDTH_OUT + 1;
    localparam int BUF_DEPTH         = 2 ** ADDRESS_WIDTH_OUT;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        FIN     = 2'd3
    } state_t;

endpackage

// File: rtl/conv_out_stream_if.sv
// rtl/conv_out_stream_if.sv - valid/ready result stream between conv_out_stream and the host bridge
interface conv_out_stream_if;
    import conv_pkg::*;

    logic [DATA_WIDTH_OUT-1:0] m_data_o;
    logic                      m_valid_o;
    logic                      m_ready_i;
    logic                      m_last_o;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );

endinterface

// File: rtl/conv_out_buf.sv
// rtl/conv_out_buf.sv - result buffer: synchronous write port, asynchronous read port
module conv_out_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] ra,
    output logic [DATA_WIDTH-1:0] rd
);

    // Contents survive reset; only frames written since start are ever streamed meaningfully.
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Capture a core result on the write edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/conv_out_stream.sv
// rtl/conv_out_stream.sv - collects conv core results and streams a frame out; CONV_OUT_PEAK_EN adds peak_o
module conv_out_stream
    import conv_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         start_i,
    input  logic                         wr_i,
    input  logic [ADDRESS_WIDTH_OUT-1:0] addr_i,
    input  logic [DATA_WIDTH_OUT-1:0]    data_i,
    input  logic                         done_i,
    conv_out_stream_if.master            m,
    output logic [COUNT_WIDTH-1:0]       len_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
`ifdef CONV_OUT_PEAK_EN
    ,
    output logic [DATA_WIDTH_OUT-1:0]    peak_o
`endif
);

    state_t                       state;
    state_t                       state_next;
    logic [COUNT_WIDTH-1:0]       len_q;
    logic [COUNT_WIDTH-1:0]       rd_ptr;
    logic [DATA_WIDTH_OUT-1:0]    data_q;
    logic                         valid_q;
    logic                         last_q;
    logic                         err_q;

    logic                         collect_wr;
    logic                         handshake;
    logic [COUNT_WIDTH-1:0]       wr_len;
    logic [COUNT_WIDTH-1:0]       eff_len;
    logic [COUNT_WIDTH-1:0]       len_m1;
    logic [COUNT_WIDTH-1:0]       nxt_ptr;
    logic [ADDRESS_WIDTH_OUT-1:0] rd_addr;
    logic [DATA_WIDTH_OUT-1:0]    rd_data;

    // A write only lands while collecting, and a start in the same cycle discards it.
    assign collect_wr = (state == COLLECT) && wr_i && !start_i;
    assign handshake  = valid_q && m.m_ready_i;
    assign wr_len     = {1'b0, addr_i} + COUNT_WIDTH'(1);
    // Length including a write in this cycle, so wr_i with done_i counts before the transition.
    assign eff_len    = (collect_wr && (wr_len > len_q)) ? wr_len : len_q;
    assign len_m1     = len_q - COUNT_WIDTH'(1);
    assign nxt_ptr    = rd_ptr + COUNT_WIDTH'(1);
    // Before the first beat the output register is primed from rd_ptr; afterwards it prefetches rd_ptr+1.
    assign rd_addr    = valid_q ? nxt_ptr[ADDRESS_WIDTH_OUT-1:0] : rd_ptr[ADDRESS_WIDTH_OUT-1:0];

    conv_out_buf #(
        .DATA_WIDTH (DATA_WIDTH_OUT),
        .ADDR_WIDTH (ADDRESS_WIDTH_OUT)
    ) u_buf (
        .clk (clk),
        .we  (collect_wr),
        .wa  (addr_i),
        .wd  (data_i),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start always wins and (re)opens a frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) state_next = COLLECT;
            end
            COLLECT: begin
                if (start_i)     state_next = COLLECT;
                else if (done_i) state_next = (eff_len != '0) ? DRAIN : FIN;
            end
            DRAIN: begin
                if (start_i)                  state_next = COLLECT;
                else if (handshake && last_q) state_next = FIN;
            end
            FIN: begin
                state_next = start_i ? COLLECT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_o = (state == COLLECT) || (state == DRAIN);
        done_o = (state == FIN);
    end

    // Frame length, read pointer, stream output register and sticky error.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            len_q   <= '0;
            rd_ptr  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (start_i) begin
            len_q   <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (state == IDLE) begin
                err_q <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_i || done_i) err_q <= 1'b1;
                end
                COLLECT: begin
                    len_q <= eff_len;
                end
                DRAIN: begin
                    if (wr_i || done_i) err_q <= 1'b1;
                    if (!valid_q) begin
                        data_q  <= rd_data;
                        valid_q <= 1'b1;
                        last_q  <= (rd_ptr == len_m1);
                    end else if (handshake) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            rd_ptr <= nxt_ptr;
                            data_q <= rd_data;
                            last_q <= (nxt_ptr == len_m1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m.m_data_o  = data_q;
    assign m.m_valid_o = valid_q;
    assign m.m_last_o  = last_q;
    assign len_o       = len_q;
    assign err_o       = err_q;

`ifdef CONV_OUT_PEAK_EN
    logic [DATA_WIDTH_OUT-1:0] peak_q;

    // Running unsigned maximum of samples accepted in the current frame.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            peak_q <= '0;
        end else if (start_i) begin
            peak_q <= '0;
        end else if (collect_wr && (data_i > peak_q)) begin
            peak_q <= data_i;
        end
    end

    assign peak_o = peak_q;
`endif

endmodule
